// File: rtl/cond_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cond_unit_pkg
// Description : Shared condition codes, flag bit positions and flag-write
//               group positions for the conditional-execution unit.
// Revision    : 1.0 - initial release
// ============================================================================
package cond_unit_pkg;

    // Instruction condition field encodings (bits 31:28)
    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111   // treated as always
    } cond_e;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Bit positions inside flag_w
    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

endpackage : cond_unit_pkg
`default_nettype wire

// File: rtl/cond_unit_check.sv
`default_nettype none
// ============================================================================
// Module      : cond_check
// Description : Pure combinational evaluation of the 4-bit condition field
//               against the architectural {N,Z,C,V} flags.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_check
    import cond_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_pass
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign w_n = flags[FLAG_N];
    assign w_z = flags[FLAG_Z];
    assign w_c = flags[FLAG_C];
    assign w_v = flags[FLAG_V];

    // Decode the condition field into a pass/fail decision
    always_comb begin
        cond_pass = 1'b0;
        case (cond_e'(cond))
            COND_EQ: cond_pass = w_z;
            COND_NE: cond_pass = ~w_z;
            COND_CS: cond_pass = w_c;
            COND_CC: cond_pass = ~w_c;
            COND_MI: cond_pass = w_n;
            COND_PL: cond_pass = ~w_n;
            COND_VS: cond_pass = w_v;
            COND_VC: cond_pass = ~w_v;
            COND_HI: cond_pass = w_c & ~w_z;
            COND_LS: cond_pass = ~w_c | w_z;
            COND_GE: cond_pass = (w_n == w_v);
            COND_LT: cond_pass = (w_n != w_v);
            COND_GT: cond_pass = ~w_z & (w_n == w_v);
            COND_LE: cond_pass = w_z | (w_n != w_v);
            COND_AL: cond_pass = 1'b1;
            COND_NV: cond_pass = 1'b1;
            default: cond_pass = 1'b1;
        endcase
    end

endmodule : cond_check
`default_nettype wire

// File: rtl/cond_unit.sv
`default_nettype none
// ============================================================================
// Module      : cond_unit
// Description : Conditional-execution unit. Owns the architectural flag
//               register, gates PC/register/memory writes by the condition
//               result, and updates the two flag groups one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_unit
    import cond_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       pcs,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       no_write,
    input  logic       stall,
    input  logic       flush,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_write,
    output logic       cond_ex,
    output logic [3:0] flags
);

    logic [3:0] r_flags;
    logic       w_cond_pass;
    logic       w_flag_upd;
    logic [3:0] w_flags_next;

    // Condition is judged against the registered flags only, so an
    // instruction never observes its own flag result.
    cond_check u_cond_check (
        .cond      (cond),
        .flags     (r_flags),
        .cond_pass (w_cond_pass)
    );

    assign cond_ex   = w_cond_pass & ~flush;
    assign pc_src    = pcs   & cond_ex;
    assign reg_write = reg_w & cond_ex & ~no_write;
    assign mem_write = mem_w & cond_ex;
    assign flags     = r_flags;

    // Stall freezes state even when the instruction otherwise executes
    assign w_flag_upd = cond_ex & ~stall;

    // Merge the enabled flag groups with the retained ones
    always_comb begin
        w_flags_next = r_flags;
        if (w_flag_upd && flag_w[FW_NZ]) begin
            w_flags_next[FLAG_N] = alu_flags[FLAG_N];
            w_flags_next[FLAG_Z] = alu_flags[FLAG_Z];
        end
        if (w_flag_upd && flag_w[FW_CV]) begin
            w_flags_next[FLAG_C] = alu_flags[FLAG_C];
            w_flags_next[FLAG_V] = alu_flags[FLAG_V];
        end
    end

    // Architectural flag register, cleared asynchronously by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= 4'b0000;
        end else begin
            r_flags <= w_flags_next;
        end
    end

endmodule : cond_unit
`default_nettype wire

// File: tb/tb_cond_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cond_unit
// Description : Scoreboard bench for cond_unit. A driver applies one vector
//               per cycle and queues the reference response; a monitor pops
//               and compares each response half a cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cond_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cond = '0;
    logic [3:0] alu_flags = '0;
    logic [1:0] flag_w = '0;
    logic       pcs = 1'b0;
    logic       reg_w = 1'b0;
    logic       mem_w = 1'b0;
    logic       no_write = 1'b0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic       pc_src;
    logic       reg_write;
    logic       mem_write;
    logic       cond_ex;
    logic [3:0] flags;

    cond_unit dut (
        .clk       (clk),
        .rst       (rst),
        .cond      (cond),
        .alu_flags (alu_flags),
        .flag_w    (flag_w),
        .pcs       (pcs),
        .reg_w     (reg_w),
        .mem_w     (mem_w),
        .no_write  (no_write),
        .stall     (stall),
        .flush     (flush),
        .pc_src    (pc_src),
        .reg_write (reg_write),
        .mem_write (mem_write),
        .cond_ex   (cond_ex),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pc_src;
        logic       reg_write;
        logic       mem_write;
        logic       cond_ex;
        logic [3:0] flags;
        string      tag;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] m_flags = 4'b0000;   // reference architectural flags
    int         n_vec  = 0;
    int         n_err  = 0;

    // Reference condition: base test from cond[3:1], inverted by cond[0],
    // with 111x meaning always.
    function automatic bit ref_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, r;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (c[3:1] != 3'd7 && c[0]) r = !r;
        return r;
    endfunction

    // rmode: 0 = no reset, 1 = reset pulse inside this cycle,
    //        2 = reset held across the following clock edge
    task automatic apply(input logic [3:0] c, input logic [3:0] af,
                         input logic [1:0] fw, input logic p, input logic rw,
                         input logic mw, input logic nw, input logic st,
                         input logic fl, input int rmode, input string tag);
        exp_t       e;
        logic [3:0] base;
        bit         ex;
        @(posedge clk);
        #1;
        cond = c; alu_flags = af; flag_w = fw; pcs = p; reg_w = rw;
        mem_w = mw; no_write = nw; stall = st; flush = fl;
        rst = (rmode != 0);
        if (rmode != 0) m_flags = 4'b0000;
        ex = ref_pass(c, m_flags) && !fl;
        e.cond_ex   = ex;
        e.pc_src    = p && ex;
        e.reg_write = rw && ex && !nw;
        e.mem_write = mw && ex;
        e.flags     = m_flags;
        e.tag       = tag;
        sb_q.push_back(e);
        base = m_flags;
        if (rmode != 2 && ex && !st) begin
            if (fw[1]) base[3:2] = af[3:2];
            if (fw[0]) base[1:0] = af[1:0];
        end
        m_flags = base;
        if (rmode == 1) begin
            @(negedge clk);
            #2;
            rst = 1'b0;
        end
    endtask

    task automatic chk(input string name, input string tag,
                       input logic [3:0] act, input logic [3:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s got=%b want=%b at %0t", tag, name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are combinational, so each vector is judged mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_vec++;
                chk("cond_ex",   e.tag, {3'b0, cond_ex},   {3'b0, e.cond_ex});
                chk("pc_src",    e.tag, {3'b0, pc_src},    {3'b0, e.pc_src});
                chk("reg_write", e.tag, {3'b0, reg_write}, {3'b0, e.reg_write});
                chk("mem_write", e.tag, {3'b0, mem_write}, {3'b0, e.mem_write});
                chk("flags",     e.tag, flags,             e.flags);
            end
        end
    end

    initial begin
        int guard;
        // Reset state, reset held across an edge with a write pending
        apply(4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0, 0, 0, 2, "rst_hold");
        apply(4'b0000, 4'b0000, 2'b00, 1, 1, 1, 0, 0, 0, 0, "post_rst_eq");
        // Mid-cycle reset with flags=1111
        apply(4'b1110, 4'b1111, 2'b11, 0, 0, 0, 0, 0, 0, 0, "set_1111");
        apply(4'b0000, 4'b0000, 2'b00, 1, 1, 1, 0, 0, 0, 0, "see_1111");
        apply(4'b0000, 4'b0000, 2'b00, 1, 1, 1, 0, 0, 0, 1, "rst_pulse_eq");
        apply(4'b0001, 4'b0000, 2'b00, 1, 1, 1, 0, 0, 0, 0, "after_rst_ne");
        apply(4'b1110, 4'b0000, 2'b00, 1, 1, 1, 0, 0, 0, 0, "after_rst_al");
        // Reset coincident with a write, then first edge writes normally
        apply(4'b1110, 4'b1001, 2'b11, 0, 0, 0, 0, 0, 0, 1, "rst_and_write");
        apply(4'b1011, 4'b0000, 2'b00, 0, 0, 1, 0, 0, 0, 0, "rst_write_lt");
        // SUBS-equal then EQ/NE
        apply(4'b1110, 4'b0110, 2'b11, 0, 0, 0, 0, 0, 0, 0, "subs_eq");
        apply(4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 0, 0, "eq_rw");
        apply(4'b0001, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 0, 0, "ne_rw");
        // Group retention
        apply(4'b1110, 4'b1111, 2'b11, 0, 0, 0, 0, 0, 0, 0, "set_1111b");
        apply(4'b1110, 4'b0000, 2'b10, 0, 0, 0, 0, 0, 0, 0, "fw_nz");
        apply(4'b1110, 4'b0001, 2'b01, 0, 0, 0, 0, 0, 0, 0, "fw_cv");
        apply(4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 0, "see_0001");
        // LT/GE with N=1,V=0
        apply(4'b1110, 4'b1000, 2'b11, 0, 0, 0, 0, 0, 0, 0, "set_1000");
        apply(4'b1011, 4'b0101, 2'b11, 0, 0, 1, 0, 0, 0, 0, "lt_write");
        apply(4'b1010, 4'b1000, 2'b11, 0, 0, 1, 0, 0, 0, 0, "ge_after");
        apply(4'b1010, 4'b1111, 2'b11, 0, 0, 1, 0, 0, 0, 0, "ge_fail");
        // Stall and flush
        apply(4'b1110, 4'b1010, 2'b11, 1, 0, 0, 0, 1, 0, 0, "stall");
        apply(4'b1110, 4'b1010, 2'b11, 1, 0, 0, 0, 0, 1, 0, "flush");
        apply(4'b1110, 4'b1010, 2'b11, 1, 0, 0, 0, 1, 1, 0, "stall_flush");
        apply(4'b1110, 4'b0000, 2'b00, 1, 0, 0, 0, 0, 0, 0, "post_sf");
        // Exhaustive cond x flags sweep with compare-class register write
        for (int f = 0; f < 16; f++) begin
            apply(4'b1110, 4'(f), 2'b11, 0, 0, 0, 0, 0, 0, 0, "sweep_set");
            for (int c = 0; c < 16; c++)
                apply(4'(c), 4'($urandom), 2'b00, 1, 1, 1, 1, 0, 0, 0, "sweep");
        end
        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            int rsel;
            rsel = int'($urandom_range(0, 63));
            apply(4'($urandom), 4'($urandom), 2'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 3) == 0),
                  (rsel == 0) ? 1 : (rsel == 1) ? 2 : 0, "rand");
        end
        apply(4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 0, "final");
        guard = 0;
        while (sb_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (sb_q.size() > 0) begin
            n_err++;
            $display("FAIL drain got=%0d pending want=0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_cond_unit
`default_nettype wire

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 The block SHALL have these ports, one per line, giving name, direction, width and meaning:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- cond  input  4  instruction condition field, bits 31:28.
- alu_flags  input  4  current ALU result flags {N,Z,C,V}.
- flag_w  input  2  from the ALU decoder; bit1 = write N,Z; bit0 = write C,V.
- pcs  input  1  decoded PC-write request.
- reg_w  input  1  decoded register-write request.
- mem_w  input  1  decoded memory-write request.
- no_write  input  1  compare-class instruction; suppresses register write.
- stall  input  1  hold; blocks flag update.
- flush  input  1  squash current instruction.
- pc_src  output  1  gated PC write.
- reg_write  output  1  gated register write.
- mem_write  output  1  gated memory write.
- cond_ex  output  1  condition passed and instruction not flushed.
- flags  output  4  architectural {N,Z,C,V} register contents.

Function
REQ-002 The unit SHALL hold a 4-bit architectural flag register, with N and Z as one write group and C and V as the other.

REQ-003 The condition check SHALL be combinational against the registered flags, not against alu_flags:
- EQ Z; NE !Z; CS C; CC !C
- MI N; PL !N; VS V; VC !V
- HI C&!Z; LS !C|Z
- GE N==V; LT N!=V
- GT !Z&(N==V); LE Z|(N!=V)
- AL 1; 1111 1

REQ-004 cond_ex SHALL equal cond_pass & !flush.

REQ-005 The gated control outputs SHALL be:
- pc_src = pcs & cond_ex
- reg_write = reg_w & cond_ex & !no_write
- mem_write = mem_w & cond_ex

REQ-006 On each rising edge where cond_ex=1, stall=0 and flag_w[1]=1, N and Z SHALL load alu_flags[3:2].

REQ-007 On each rising edge where cond_ex=1, stall=0 and flag_w[0]=1, C and V SHALL load alu_flags[1:0].

REQ-008 Flag groups whose write bit is 0 SHALL retain their value.

REQ-009 Flag write latency SHALL be exactly one cycle: an instruction never sees its own flag update, and the next instruction does.

REQ-010 If stall and flush are asserted together, flush SHALL govern the outputs and stall SHALL govern state; in either case no flag update occurs.

REQ-011 A failed condition SHALL suppress both the flag update and all gated writes, including the flag update of a compare instruction.

REQ-012 The flags output SHALL present the register contents directly, with no bypass from alu_flags.

REQ-013 All outputs other than flags SHALL have zero sequential latency and no internal state beyond the flag register.

Reset
REQ-014 Asserting rst SHALL clear flags to 4'b0000 immediately, independent of clk.

REQ-015 While rst is high, the flag register SHALL hold 0 regardless of flag_w or stall.

REQ-016 With the flags cleared by reset, the outputs SHALL follow the condition table: EQ fails, NE passes, AL passes, and gated outputs track those results.

REQ-017 If rst asserts in the same cycle as a flag write, reset SHALL win; on deassertion, the first qualifying edge writes normally.

Structure
REQ-018 A shared package SHALL hold:
- the 4-bit condition-code enum (EQ..AL, plus the 1111 encoding)
- the flag bit index constants N=3, Z=2, C=1, V=0
- the flag_w group bit positions

REQ-019 The condition evaluation SHALL be a separate combinational sub-module, cond_check, with inputs cond and flags and output cond_pass; cond_unit owns the register and the gating.

Verification
REQ-020 Scenario: rst pulse mid-cycle with flags=1111 -> flags reads 0000 before the next clk edge; cond=EQ gives cond_ex=0, cond=NE gives cond_ex=1.

REQ-021 Scenario: cond=AL, flag_w=11, alu_flags=0110 (SUBS equal) -> next cycle flags=0110; then cond=EQ, reg_w=1 -> reg_write=1, and cond=NE -> reg_write=0.

REQ-022 Scenario: flags=1111, flag_w=10, alu_flags=0000 -> flags=0011 (C,V retained); flag_w=01, alu_flags=0001 -> flags=0001.

REQ-023 Scenario: flags=1000 (N=1,V=0), cond=LT, mem_w=1, flag_w=11 -> mem_write=1 and flags update; cond=GE -> mem_write=0 and flags unchanged.

REQ-024 Scenario: cond=AL, pcs=1, flag_w=11, alu_flags=1010, with stall=1 -> pc_src=1 and flags unchanged; with flush=1 -> pc_src=0, cond_ex=0, flags unchanged.

REQ-025 Scenario: exhaustive sweep of all 16 cond values x 16 flag values -> cond_pass matches the REQ-003 table; no_write=1, reg_w=1 -> reg_write=0 in every case.
